pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Resolves stall requests from ID, EX and MEM into a per-stage hold vector for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Sequences multi-cycle EX operations with an internal down-counter.
- Issues PC redirects and pipeline flushes for taken branches and exceptions. A branch that arrives while IF_ID is held is deferred until the hold releases.

Parameters:
- ADDR_W, 32, PC/address width (matches instruction address bus).
- CNT_W, 6, width of the multi-cycle length field (max op length 2^CNT_W-1 cycles).
- EXC_VECTOR, 32'h0000_0020, PC loaded on exception.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stallreq_id  in  1  ID hazard (load-use) hold request.
- stallreq_ex  in  1  EX hold request (single cycle, level).
- stallreq_mem  in  1  MEM wait-state hold request.
- ex_multi_start  in  1  EX begins a multi-cycle op this cycle.
- ex_multi_cycles  in  CNT_W  length N of that op, in cycles.
- branch_flag  in  1  ID resolved a taken branch this cycle.
- branch_target  in  ADDR_W  branch destination.
- excp_valid  in  1  MEM commits an exception this cycle.
- stall  out  6  hold vector: bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 reserved (always 0).
- flush_all  out  1  clear IF_ID, ID_EX, EX_MEM to bubbles.
- flush_ifid  out  1  clear IF_ID only (branch shadow).
- redirect  out  1  PC loads new_pc this cycle.
- new_pc  out  ADDR_W  redirect target.
- multi_busy  out  1  multi-cycle op in progress.
- multi_done  out  1  final cycle of a multi-cycle op.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, pend=0, pend_pc=0. All outputs 0, new_pc=0.
- FSM states:
  - IDLE: no multi-cycle op in progress.
  - MULTI: counting down a multi-cycle op.
- Outputs are combinational from the current inputs and registered state (zero-latency hold). State, cnt and pend update on the rising clk edge.
- Stall request vector (highest priority first):
  - excp_valid → 000000.
  - stallreq_mem → 011111.
  - stallreq_ex, or state==MULTI, or (IDLE & ex_multi_start & N>=1) → 001111.
  - stallreq_id → 000111.
  - otherwise → 000000.
- Multi-cycle sequencing:
  - IDLE & ex_multi_start & N>=2: stall this cycle; next state MULTI, cnt=N-1.
  - IDLE & ex_multi_start & N==1: stall this cycle only; multi_done=1; stay IDLE.
  - N==0: start is ignored; no stall.
  - MULTI: cnt decrements each edge, including edges where stallreq_mem also holds.
  - MULTI with cnt==1: multi_done=1; next state IDLE.
  - Total EX hold is exactly N cycles, counting the start cycle.
  - multi_busy=1 exactly when state==MULTI.
  - ex_multi_start while in MULTI is ignored.
- Exception:
  - excp_valid=1 → flush_all=1, redirect=1, new_pc=EXC_VECTOR, flush_ifid=0, stall=0.
  - Next state IDLE, cnt=0, pend=0; the aborted op gives no multi_done.
- Branch:
  - branch_flag & stall[1]==0 & !excp_valid → redirect=1, flush_ifid=1, new_pc=branch_target.
  - branch_flag & stall[1]==1 → latch pend=1, pend_pc=branch_target; no redirect.
  - pend & stall[1]==0 & !excp_valid → redirect=1, flush_ifid=1, new_pc=pend_pc; pend clears on the next edge.
  - A new branch_flag is not expected while pend=1. If one arrives, it overwrites pend_pc.
- Simultaneous events: an exception overrides any branch or pending redirect in the same cycle.
- Reset mid-operation: everything returns to reset values immediately, without waiting for clk.

Decomposition:
- Shared package `pipe_pkg`:
  - stall vector constants STALL_NONE/ID/EX/MEM.
  - stage bit index localparams.
  - state enum ctrl_state_t {IDLE, MULTI}.
  - EXC_VECTOR default.
- Optional sub-module `multi_cnt`: loadable down-counter with zero/one flags, CNT_W wide. The priority mux and FSM stay in pipe_ctrl.

Test Plan:
- Reset: hold rst=0 with inputs toggling → stall=0, redirect=0, flush_*=0, new_pc=0. Release → still 0 with idle inputs.
- Priority: stallreq_id=1 → stall=000111; add stallreq_ex → 001111; add stallreq_mem → 011111; add excp_valid → 000000, flush_all=1, new_pc=0x20.
- Multi-cycle: ex_multi_start with N=5 → stall=001111 for exactly 5 cycles; multi_busy high cycles 2–5; multi_done only in cycle 5. Repeat with N=1 (1-cycle stall, multi_done in the same cycle) and N=0 (no stall).
- Deferred branch: stallreq_id=1 and branch_flag with target 0x400 → no redirect. Drop stallreq_id two cycles later → one-cycle redirect=1, flush_ifid=1, new_pc=0x400, then pend clear.
- Exception abort: start an op with N=8; excp_valid in its 3rd cycle → flush_all=1, new_pc=0x20; next cycle multi_busy=0, stall=0, multi_done never pulses.
- Async reset mid-op: N=10 running, pend set; pulse rst low between edges → outputs 0 immediately; after release, state IDLE and no pending redirect.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: hold-vector encodings,
// stage bit positions, controller state type and default exception vector.
package pipe_pkg;

    localparam int STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam int STAGE_PC    = 0;
    localparam int STAGE_IFID  = 1;
    localparam int STAGE_IDEX  = 2;
    localparam int STAGE_EXMEM = 3;
    localparam int STAGE_MEMWB = 4;
    localparam int STAGE_RSVD  = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } ctrl_state_t;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

endpackage

// File: rtl/multi_cnt.sv
// Loadable down-counter used to time multi-cycle EX operations.
// Clear wins over load, load wins over decrement; it never wraps below zero.
module multi_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign zero_o = (cnt_q == {CNT_W{1'b0}});
    assign one_o  = (cnt_q == CNT_W'(1));

    // Next count selection.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: hold vector, multi-cycle EX sequencing,
// branch/exception redirects with deferral of branches while IF_ID is held.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                CNT_W      = 6,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              ex_multi_start,
    input  logic [CNT_W-1:0]  ex_multi_cycles,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              excp_valid,
    output logic [5:0]        stall,
    output logic              flush_all,
    output logic              flush_ifid,
    output logic              redirect,
    output logic [ADDR_W-1:0] new_pc,
    output logic              multi_busy,
    output logic              multi_done
);

    ctrl_state_t       state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic n_is_zero_s;
    logic n_is_one_s;
    logic start_ok_s;
    logic cnt_clr_s;
    logic cnt_load_s;
    logic cnt_dec_s;
    logic cnt_zero_s;
    logic cnt_one_s;

    assign n_is_zero_s = (ex_multi_cycles == {CNT_W{1'b0}});
    assign n_is_one_s  = (ex_multi_cycles == CNT_W'(1));
    assign start_ok_s  = (state_q == IDLE) && ex_multi_start && !n_is_zero_s;

    multi_cnt #(
        .CNT_W (CNT_W)
    ) u_multi_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr_s),
        .load_i     (cnt_load_s),
        .load_val_i (ex_multi_cycles - CNT_W'(1)),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s),
        .one_o      (cnt_one_s)
    );

    // Zero-latency outputs; forced quiet while reset is asserted.
    always_comb begin
        stall      = STALL_NONE;
        flush_all  = 1'b0;
        flush_ifid = 1'b0;
        redirect   = 1'b0;
        new_pc     = {ADDR_W{1'b0}};
        multi_done = 1'b0;
        multi_busy = (state_q == MULTI);
        if (!rst) begin
            multi_busy = 1'b0;
        end else if (excp_valid) begin
            flush_all = 1'b1;
            redirect  = 1'b1;
            new_pc    = EXC_VECTOR;
        end else begin
            if (stallreq_mem) begin
                stall = STALL_MEM;
            end else if (stallreq_ex || (state_q == MULTI) || start_ok_s) begin
                stall = STALL_EX;
            end else if (stallreq_id) begin
                stall = STALL_ID;
            end else begin
                stall = STALL_NONE;
            end

            // A fresh branch supersedes an older deferred one.
            if (!stall[STAGE_IFID] && branch_flag) begin
                redirect   = 1'b1;
                flush_ifid = 1'b1;
                new_pc     = branch_target;
            end else if (!stall[STAGE_IFID] && pend_q) begin
                redirect   = 1'b1;
                flush_ifid = 1'b1;
                new_pc     = pend_pc_q;
            end else begin
                redirect   = 1'b0;
                flush_ifid = 1'b0;
            end

            multi_done = (start_ok_s && n_is_one_s) || ((state_q == MULTI) && cnt_one_s);
        end
    end

    // Next-state for the controller FSM, counter commands and branch deferral.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        cnt_clr_s  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        if (excp_valid) begin
            state_d   = IDLE;
            pend_d    = 1'b0;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok_s && !n_is_one_s) begin
                        state_d    = MULTI;
                        cnt_load_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                MULTI: begin
                    cnt_dec_s = 1'b1;
                    // A zero count here is unreachable; leave rather than hang.
                    if (cnt_one_s || cnt_zero_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = MULTI;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_clr_s = 1'b1;
                end
            endcase

            if (branch_flag && stall[STAGE_IFID]) begin
                pend_d    = 1'b1;
                pend_pc_d = branch_target;
            end else if (redirect) begin
                pend_d = 1'b0;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            pend_pc_q <= {ADDR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle model of the controller's rules
// checked every falling edge, plus directed scenarios with literal expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        ex_multi_start;
    logic [5:0]  ex_multi_cycles;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        excp_valid;
    logic [5:0]  stall;
    logic        flush_all, flush_ifid, redirect;
    logic [31:0] new_pc;
    logic        multi_busy, multi_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_id     (stallreq_id),
        .stallreq_ex     (stallreq_ex),
        .stallreq_mem    (stallreq_mem),
        .ex_multi_start  (ex_multi_start),
        .ex_multi_cycles (ex_multi_cycles),
        .branch_flag     (branch_flag),
        .branch_target   (branch_target),
        .excp_valid      (excp_valid),
        .stall           (stall),
        .flush_all       (flush_all),
        .flush_ifid      (flush_ifid),
        .redirect        (redirect),
        .new_pc          (new_pc),
        .multi_busy      (multi_busy),
        .multi_done      (multi_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: remaining EX cycles of the running op, and one deferred branch.
    int          m_left = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    logic [5:0]  e_stall;
    logic        e_fa, e_fi, e_rd, e_busy, e_done, acc, held;
    logic [31:0] e_pc;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0; m_pend = 1'b0; m_pend_pc = 32'h0;
        end
        if (!clk) begin
            acc = ex_multi_start && (m_left == 0) && (ex_multi_cycles != 6'd0);
            e_stall = 6'b000000; e_fa = 1'b0; e_fi = 1'b0; e_rd = 1'b0;
            e_pc = 32'h0; e_busy = 1'b0; e_done = 1'b0;
            if (rst) begin
                e_busy = (m_left > 0);
                if (excp_valid) begin
                    e_fa = 1'b1; e_rd = 1'b1; e_pc = 32'h0000_0020;
                end else begin
                    if (stallreq_mem) e_stall = 6'b011111;
                    else if (stallreq_ex || m_left > 0 || acc) e_stall = 6'b001111;
                    else if (stallreq_id) e_stall = 6'b000111;
                    held = e_stall[1];
                    if (!held && branch_flag) begin
                        e_rd = 1'b1; e_fi = 1'b1; e_pc = branch_target;
                    end else if (!held && m_pend) begin
                        e_rd = 1'b1; e_fi = 1'b1; e_pc = m_pend_pc;
                    end
                    e_done = (m_left == 1) || (acc && ex_multi_cycles == 6'd1);
                end
            end
            chk("cmp_stall", {26'd0, stall}, {26'd0, e_stall});
            chk("cmp_flush_all", {31'd0, flush_all}, {31'd0, e_fa});
            chk("cmp_flush_ifid", {31'd0, flush_ifid}, {31'd0, e_fi});
            chk("cmp_redirect", {31'd0, redirect}, {31'd0, e_rd});
            chk("cmp_new_pc", new_pc, e_pc);
            chk("cmp_busy", {31'd0, multi_busy}, {31'd0, e_busy});
            chk("cmp_done", {31'd0, multi_done}, {31'd0, e_done});
            if (rst) begin
                if (excp_valid) begin
                    m_left = 0; m_pend = 1'b0;
                end else begin
                    if (m_left > 0) m_left = m_left - 1;
                    else if (acc) m_left = int'(ex_multi_cycles) - 1;
                    if (branch_flag && e_stall[1]) begin
                        m_pend = 1'b1; m_pend_pc = branch_target;
                    end else if (e_rd) begin
                        m_pend = 1'b0;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        ex_multi_start = 1'b0; ex_multi_cycles = 6'd0;
        branch_flag = 1'b0; branch_target = 32'h0; excp_valid = 1'b0;
    endtask

    // Runs one op of length n from IDLE and tallies held/busy/done cycles.
    task automatic run_op(input logic [5:0] n, input int ncyc,
                          output int held_c, output int busy_c, output int done_at);
        held_c = 0; busy_c = 0; done_at = 0;
        for (int c = 1; c <= ncyc; c++) begin
            ex_multi_start  = (c == 1);
            ex_multi_cycles = n;
            #1;
            if (stall == 6'b001111) held_c++;
            if (multi_busy) busy_c++;
            if (multi_done) done_at = (done_at == 0) ? c : -1;
            next_cycle();
        end
        ex_multi_start = 1'b0;
    endtask

    int h, b, d;

    initial begin
        rst = 1'b0;
        idle_inputs();
        #1;
        for (int i = 0; i < 4; i++) begin
            stallreq_id = i[0]; stallreq_mem = i[1]; branch_flag = 1'b1;
            branch_target = 32'h100 + i; ex_multi_start = 1'b1; ex_multi_cycles = 6'd3;
            #1;
            chk("rst_stall", {26'd0, stall}, 32'd0);
            chk("rst_redirect", {31'd0, redirect}, 32'd0);
            chk("rst_new_pc", new_pc, 32'd0);
            next_cycle();
        end
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        #1;
        chk("post_rst_stall", {26'd0, stall}, 32'd0);
        next_cycle();

        // Priority ladder.
        stallreq_id = 1'b1; #1;
        chk("prio_id", {26'd0, stall}, 32'h07);
        next_cycle();
        stallreq_ex = 1'b1; #1;
        chk("prio_ex", {26'd0, stall}, 32'h0F);
        next_cycle();
        stallreq_mem = 1'b1; #1;
        chk("prio_mem", {26'd0, stall}, 32'h1F);
        next_cycle();
        excp_valid = 1'b1; #1;
        chk("prio_excp_stall", {26'd0, stall}, 32'h00);
        chk("prio_excp_flush", {31'd0, flush_all}, 32'd1);
        chk("prio_excp_pc", new_pc, 32'h20);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Multi-cycle lengths 5, 1, 0.
        run_op(6'd5, 7, h, b, d);
        chk("n5_held", h, 32'd5); chk("n5_busy", b, 32'd4); chk("n5_done", d, 32'd5);
        run_op(6'd1, 3, h, b, d);
        chk("n1_held", h, 32'd1); chk("n1_busy", b, 32'd0); chk("n1_done", d, 32'd1);
        run_op(6'd0, 3, h, b, d);
        chk("n0_held", h, 32'd0); chk("n0_done", d, 32'd0);

        // Deferred branch.
        stallreq_id = 1'b1; branch_flag = 1'b1; branch_target = 32'h400; #1;
        chk("defer_no_redirect", {31'd0, redirect}, 32'd0);
        next_cycle();
        branch_flag = 1'b0; branch_target = 32'h0; #1;
        chk("defer_hold", {31'd0, redirect}, 32'd0);
        next_cycle();
        stallreq_id = 1'b0; #1;
        chk("defer_redirect", {31'd0, redirect}, 32'd1);
        chk("defer_flush_ifid", {31'd0, flush_ifid}, 32'd1);
        chk("defer_pc", new_pc, 32'h400);
        next_cycle();
        #1;
        chk("defer_cleared", {31'd0, redirect}, 32'd0);
        next_cycle();

        // Exception aborts an 8-cycle op in its 3rd cycle.
        ex_multi_start = 1'b1; ex_multi_cycles = 6'd8;
        next_cycle();
        ex_multi_start = 1'b0;
        next_cycle();
        excp_valid = 1'b1; #1;
        chk("abort_flush", {31'd0, flush_all}, 32'd1);
        chk("abort_pc", new_pc, 32'h20);
        chk("abort_stall", {26'd0, stall}, 32'd0);
        next_cycle();
        excp_valid = 1'b0; d = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0) begin
                chk("abort_busy", {31'd0, multi_busy}, 32'd0);
                chk("abort_stall_after", {26'd0, stall}, 32'd0);
            end
            if (multi_done) d++;
            next_cycle();
        end
        chk("abort_no_done", d, 32'd0);

        // Async reset mid-op with a pending branch.
        ex_multi_start = 1'b1; ex_multi_cycles = 6'd10;
        next_cycle();
        ex_multi_start = 1'b0; branch_flag = 1'b1; branch_target = 32'h800;
        next_cycle();
        branch_flag = 1'b0; stallreq_id = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("arst_stall", {26'd0, stall}, 32'd0);
        chk("arst_busy", {31'd0, multi_busy}, 32'd0);
        chk("arst_redirect", {31'd0, redirect}, 32'd0);
        #1 rst = 1'b1;
        next_cycle();
        stallreq_id = 1'b0; #1;
        chk("arst_after_redirect", {31'd0, redirect}, 32'd0);
        chk("arst_after_busy", {31'd0, multi_busy}, 32'd0);
        chk("arst_after_stall", {26'd0, stall}, 32'd0);
        next_cycle();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
